// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
//   DATA_W      : data bus width, taken from `DATA_WIDTH (defaults to 32 when not
//                 already defined by the core's common header).
//   WIDTH_W     : write-width field width.
//   M_FETCH/M_EXEC : master indices (fetch is master 0).
//   arb_state_t : arbiter FSM states.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

  localparam int unsigned DATA_W  = `DATA_WIDTH;
  localparam int unsigned WIDTH_W = 3;

  localparam int unsigned M_FETCH = 0;
  localparam int unsigned M_EXEC  = 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   req      : request per master.
//   last_gnt : index of the master granted most recently.
//   pick     : one-hot choice; a lone requester always wins, a tie goes to the
//              master that was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (&req) begin
      pick = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter (master 0 = fetch, master 1 = execute).
// A grant is issued one cycle after a request and held until the granted master
// completes a read or write handshake or withdraws its request; one idle cycle
// always follows a grant. Master signals are muxed combinationally from the
// registered grant.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset.
//   i_m_* / o_m_*            : per-master request/response (flattened, master 0 in LSBs).
//   o_addr .. o_rd_ready     : request towards memory.
//   i_wr_ready, i_data, i_rd_valid : response from memory.
//   o_gnt, o_busy            : registered one-hot grant and grant-held flag.
// Optional: define MEM_ARB_TIMEOUT_EN to add a per-grant watchdog (TIMEOUT_CYCLES)
// with o_timeout / o_timeout_m outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_M = 2
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_M*32-1:0]        i_m_addr,
  input  logic [NUM_M*DATA_W-1:0]    i_m_data,
  input  logic [NUM_M-1:0]           i_m_wr_valid,
  output logic [NUM_M-1:0]           o_m_wr_ready,
  input  logic [NUM_M*WIDTH_W-1:0]   i_m_wr_width,
  output logic [DATA_W-1:0]          o_m_data,
  output logic [NUM_M-1:0]           o_m_rd_valid,
  input  logic [NUM_M-1:0]           i_m_rd_ready,
  output logic [31:0]                o_addr,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_wr_valid,
  output logic [WIDTH_W-1:0]         o_wr_width,
  output logic                       o_rd_ready,
  input  logic                       i_wr_ready,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_rd_valid,
  output logic [NUM_M-1:0]           o_gnt,
  output logic                       o_busy
`ifdef MEM_ARB_TIMEOUT_EN
  , output logic                     o_timeout,
  output logic                       o_timeout_m
`endif
);

  arb_state_t       state_q;
  logic [NUM_M-1:0] gnt_q;
  logic             last_gnt_q;
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] pick;
  logic             complete;
  logic             req_held;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
`endif

  assign req = i_m_rd_ready | i_m_wr_valid;

  rr_pick2 u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .pick     (pick)
  );

  // Memory-side mux driven only by the registered grant.
  always_comb begin
    o_addr     = '0;
    o_data     = '0;
    o_wr_valid = 1'b0;
    o_wr_width = '0;
    o_rd_ready = 1'b0;
    unique case (1'b1)
      gnt_q[M_FETCH]: begin
        o_addr     = i_m_addr[M_FETCH*32 +: 32];
        o_data     = i_m_data[M_FETCH*DATA_W +: DATA_W];
        o_wr_valid = i_m_wr_valid[M_FETCH];
        o_wr_width = i_m_wr_width[M_FETCH*WIDTH_W +: WIDTH_W];
        o_rd_ready = i_m_rd_ready[M_FETCH];
      end
      gnt_q[M_EXEC]: begin
        o_addr     = i_m_addr[M_EXEC*32 +: 32];
        o_data     = i_m_data[M_EXEC*DATA_W +: DATA_W];
        o_wr_valid = i_m_wr_valid[M_EXEC];
        o_wr_width = i_m_wr_width[M_EXEC*WIDTH_W +: WIDTH_W];
        o_rd_ready = i_m_rd_ready[M_EXEC];
      end
      default: ;
    endcase
  end

  assign o_m_wr_ready = gnt_q & {NUM_M{i_wr_ready}};
  assign o_m_rd_valid = gnt_q & {NUM_M{i_rd_valid}};
  // Read data is a broadcast; it is only blanked so every output reads 0 in reset.
  assign o_m_data     = i_rst_n ? i_data : '0;
  assign o_gnt        = gnt_q;
  assign o_busy       = |gnt_q;

  assign complete = (o_rd_ready & i_rd_valid) | (o_wr_valid & i_wr_ready);
  assign req_held = |(gnt_q & req);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      last_gnt_q  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      o_timeout   <= 1'b0;
      o_timeout_m <= 1'b0;
`endif
    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
      o_timeout   <= 1'b0;
      o_timeout_m <= 1'b0;
`endif
      unique case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            state_q    <= pick[M_EXEC] ? ARB_GRANT1 : ARB_GRANT0;
            gnt_q      <= pick;
            last_gnt_q <= pick[M_EXEC];
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end
        end
        ARB_GRANT0, ARB_GRANT1: begin
          // Completion or withdrawal releases the grant; the next cycle is idle.
          if (complete || !req_held) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            o_timeout   <= 1'b1;
            o_timeout_m <= gnt_q[M_EXEC];
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random traffic.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW  = DATA_W;
  localparam int TMO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus variables
  logic [31:0]   m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [2:0]    m_width [2];
  logic          m_rd    [2];
  logic          m_wr    [2];
  logic          mem_wr_ready, mem_rd_valid;
  logic [DW-1:0] mem_data;

  // DUT connections
  logic [63:0]       i_m_addr;
  logic [2*DW-1:0]   i_m_data;
  logic [1:0]        i_m_wr_valid, i_m_rd_ready;
  logic [5:0]        i_m_wr_width;
  logic [1:0]        o_m_wr_ready, o_m_rd_valid, o_gnt;
  logic [DW-1:0]     o_m_data, o_data;
  logic [31:0]       o_addr;
  logic              o_wr_valid, o_rd_ready, o_busy, o_timeout, o_timeout_m;
  logic [2:0]        o_wr_width;

  assign i_m_addr     = {m_addr[1], m_addr[0]};
  assign i_m_data     = {m_wdata[1], m_wdata[0]};
  assign i_m_wr_width = {m_width[1], m_width[0]};
  assign i_m_wr_valid = {m_wr[1], m_wr[0]};
  assign i_m_rd_ready = {m_rd[1], m_rd[0]};
`ifndef MEM_ARB_TIMEOUT_EN
  assign o_timeout   = 1'b0;
  assign o_timeout_m = 1'b0;
`endif

  mem_arbiter #(
    .NUM_M(2)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_m_addr     (i_m_addr),
    .i_m_data     (i_m_data),
    .i_m_wr_valid (i_m_wr_valid),
    .o_m_wr_ready (o_m_wr_ready),
    .i_m_wr_width (i_m_wr_width),
    .o_m_data     (o_m_data),
    .o_m_rd_valid (o_m_rd_valid),
    .i_m_rd_ready (i_m_rd_ready),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_wr_valid   (o_wr_valid),
    .o_wr_width   (o_wr_width),
    .o_rd_ready   (o_rd_ready),
    .i_wr_ready   (mem_wr_ready),
    .i_data       (mem_data),
    .i_rd_valid   (mem_rd_valid),
    .o_gnt        (o_gnt),
    .o_busy       (o_busy)
`ifdef MEM_ARB_TIMEOUT_EN
    , .o_timeout  (o_timeout),
    .o_timeout_m  (o_timeout_m)
`endif
  );

  typedef struct packed {
    logic [1:0]    gnt;
    logic          busy;
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic          wr_valid;
    logic [2:0]    wr_width;
    logic          rd_ready;
    logic [1:0]    m_wr_ready;
    logic [1:0]    m_rd_valid;
    logic [DW-1:0] m_data;
    logic          timeout;
    logic          timeout_m;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the memory this cycle (-1 = nobody).
  int         owner = -1;
  int         last = 1;
  int         gcnt = 0;
  bit         tmo_pend = 1'b0;
  int         tmo_m = 0;
  logic [1:0] done_mask = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_wdata[m] = '0; m_width[m] = '0; m_rd[m] = 1'b0; m_wr[m] = 1'b0;
    end
    mem_wr_ready = 1'b0; mem_rd_valid = 1'b0; mem_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt"}, 64'(o_gnt), 64'd0);
    check({tag, ".busy"}, 64'(o_busy), 64'd0);
    check({tag, ".addr"}, 64'(o_addr), 64'd0);
    check({tag, ".data"}, 64'(o_data), 64'd0);
    check({tag, ".wr_valid"}, 64'(o_wr_valid), 64'd0);
    check({tag, ".wr_width"}, 64'(o_wr_width), 64'd0);
    check({tag, ".rd_ready"}, 64'(o_rd_ready), 64'd0);
    check({tag, ".m_wr_ready"}, 64'(o_m_wr_ready), 64'd0);
    check({tag, ".m_rd_valid"}, 64'(o_m_rd_valid), 64'd0);
    check({tag, ".m_data"}, 64'(o_m_data), 64'd0);
  endtask

  // Called at posedge+1 with inputs for this cycle already set: records what the
  // outputs must be this cycle, advances the model, then waits for the next cycle.
  task automatic tick();
    exp_t e;
    bit   rq [2];
    bit   fin;
    e = '0;
    e.m_data = mem_data;
    e.timeout = tmo_pend;
    e.timeout_m = (tmo_m == 1);
    if (owner >= 0) begin
      e.gnt[owner] = 1'b1;
      e.busy = 1'b1;
      e.addr = m_addr[owner];
      e.data = m_wdata[owner];
      e.wr_valid = m_wr[owner];
      e.wr_width = m_width[owner];
      e.rd_ready = m_rd[owner];
      e.m_wr_ready[owner] = mem_wr_ready;
      e.m_rd_valid[owner] = mem_rd_valid;
    end
    q.push_back(e);

    tmo_pend = 1'b0;
    tmo_m = 0;
    done_mask = 2'b00;
    for (int m = 0; m < 2; m++) rq[m] = m_rd[m] || m_wr[m];
    if (owner >= 0) begin
      fin = (m_rd[owner] && mem_rd_valid) || (m_wr[owner] && mem_wr_ready);
      gcnt++;
      if (fin) begin
        done_mask[owner] = 1'b1;
        owner = -1;
      end else if (!rq[owner]) begin
        owner = -1;
      end else if (TimeoutOn && gcnt == TMO) begin
        tmo_pend = 1'b1;
        tmo_m = owner;
        done_mask[owner] = 1'b1;
        owner = -1;
      end
    end else if (rq[0] || rq[1]) begin
      owner = (rq[0] && rq[1]) ? 1 - last : (rq[0] ? 0 : 1);
      last = owner;
      gcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    owner = -1; last = 1; gcnt = 0; tmo_pend = 1'b0; tmo_m = 0; done_mask = 2'b00;
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      check("gnt", 64'(o_gnt), 64'(mon_e.gnt));
      check("busy", 64'(o_busy), 64'(mon_e.busy));
      check("addr", 64'(o_addr), 64'(mon_e.addr));
      check("data", 64'(o_data), 64'(mon_e.data));
      check("wr_valid", 64'(o_wr_valid), 64'(mon_e.wr_valid));
      check("wr_width", 64'(o_wr_width), 64'(mon_e.wr_width));
      check("rd_ready", 64'(o_rd_ready), 64'(mon_e.rd_ready));
      check("m_wr_ready", 64'(o_m_wr_ready), 64'(mon_e.m_wr_ready));
      check("m_rd_valid", 64'(o_m_rd_valid), 64'(mon_e.m_rd_valid));
      check("m_data", 64'(o_m_data), 64'(mon_e.m_data));
`ifdef MEM_ARB_TIMEOUT_EN
      check("timeout", 64'(o_timeout), 64'(mon_e.timeout));
      check("timeout_m", 64'(o_timeout_m), 64'(mon_e.timeout_m));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  bit act [2];
  bit iswr [2];

  initial begin
    clear_inputs();
    mem_data = 32'hFFFF_0001;
    mem_rd_valid = 1'b1;
    mem_wr_ready = 1'b1;
    #12;
    check_all_zero("reset");
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single read by fetch
    m_rd[0] = 1'b1; m_addr[0] = 32'h100;
    tick(); tick(); tick();
    mem_rd_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    clear_inputs();
    tick(); tick();

    // Tie from reset state (last_gnt reset = 1, fetch wins first)
    m_rd[0] = 1'b1; m_rd[1] = 1'b1; m_addr[0] = 32'h40; m_addr[1] = 32'h80;
    mem_rd_valid = 1'b1; mem_data = 32'h1234_5678;
    for (int i = 0; i < 8; i++) tick();
    clear_inputs();
    tick();

    // Write routing from execute
    m_wr[1] = 1'b1; m_addr[1] = 32'h2000; m_wdata[1] = 32'h55; m_width[1] = 3'b010;
    tick(); tick();
    mem_wr_ready = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();

    // Withdrawal by execute with fetch pending
    m_rd[1] = 1'b1; m_addr[1] = 32'h3000;
    tick(); tick();
    m_rd[1] = 1'b0; m_rd[0] = 1'b1; m_addr[0] = 32'h500;
    tick(); tick(); tick();
    mem_rd_valid = 1'b1;
    tick();
    clear_inputs();
    tick();

    // Asynchronous reset mid-grant
    m_rd[0] = 1'b1; m_addr[0] = 32'hABC0; m_wr[1] = 1'b1; m_addr[1] = 32'h77;
    tick(); tick();
    mem_data = 32'hA5A5_5A5A; mem_rd_valid = 1'b1; mem_wr_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
    m_wr[1] = 1'b0; m_rd[1] = 1'b1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    mem_rd_valid = 1'b1;
    tick();
    clear_inputs();
    tick(); tick(); tick(); tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Stuck fetch read: watchdog releases the grant
    m_rd[0] = 1'b1; m_addr[0] = 32'h900;
    for (int i = 0; i < TMO + 4; i++) begin
      if (done_mask[0]) m_rd[0] = 1'b0;
      tick();
    end
    clear_inputs();
    tick();
`endif

    // Random traffic
    act[0] = 1'b0; act[1] = 1'b0; iswr[0] = 1'b0; iswr[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (done_mask[m]) act[m] = 1'b0;
        if (!act[m]) begin
          if ($urandom_range(3) == 0) begin
            act[m] = 1'b1;
            iswr[m] = 1'($urandom_range(1));
            m_addr[m] = $urandom;
            m_wdata[m] = DW'($urandom);
            m_width[m] = 3'($urandom_range(7));
          end
        end else begin
          if ($urandom_range(24) == 0) act[m] = 1'b0;
          if ($urandom_range(9) == 0) m_addr[m] = $urandom;
        end
        m_rd[m] = act[m] && !iswr[m];
        m_wr[m] = act[m] && iswr[m];
      end
      mem_rd_valid = ($urandom_range(2) == 0);
      mem_wr_ready = ($urandom_range(2) == 0);
      mem_data = DW'($urandom);
      tick();
    end
    clear_inputs();
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the core's single memory interface between the instruction-fetch port (master 0) and the execute/data port (master 1). It replaces the state-based address/data multiplexer so that fetch and execute can issue requests independently, including a future prefetching fetch unit. It uses the same valid/ready read/write handshake as the memory interface. A grant is held until the granted master's transaction completes.

Parameters:
- NUM_M, 2, number of masters; fixed at 2, and index 0 is fetch.
- TIMEOUT_CYCLES, 256, watchdog limit on cycles per grant. Used only when the optional feature is enabled.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_m_addr  in  NUM_M x 32  per-master address.
- i_m_data  in  NUM_M x `DATA_WIDTH  per-master write data.
- i_m_wr_valid  in  NUM_M  per-master write request.
- o_m_wr_ready  out  NUM_M  per-master write accept.
- i_m_wr_width  in  NUM_M x 3  per-master write width.
- o_m_data  out  `DATA_WIDTH  read data, broadcast to all masters.
- o_m_rd_valid  out  NUM_M  per-master read data valid.
- i_m_rd_ready  in  NUM_M  per-master read request.
- o_addr, o_data, o_wr_valid, o_wr_width, o_rd_ready  out  32/`DATA_WIDTH/1/3/1  to memory.
- i_wr_ready, i_data, i_rd_valid  in  1/`DATA_WIDTH/1  from memory.
- o_gnt  out  NUM_M  one-hot registered grant.
- o_busy  out  1  high while any grant is held.

Behaviour:
- Request definition: req[i] = i_m_rd_ready[i] | i_m_wr_valid[i].
- Completion of master g: (o_rd_ready & i_rd_valid) | (o_wr_valid & i_wr_ready), evaluated while g is granted.
- States:
  - IDLE: no grant. If any req is high, move to GRANT0 or GRANT1 at the next clock edge.
  - GRANTn: hold the grant. Move to IDLE after the completion cycle, or when req[n] drops to 0 (withdrawal).
- Arbitration when both requests are high in IDLE: round-robin. Grant the master that is not last_gnt.
  - last_gnt updates when a grant is issued.
  - Reset value of last_gnt is 1, so fetch wins the first tie.
- With a single requester, that requester is granted regardless of last_gnt.
- Latency: a request at cycle N gives o_gnt at N+1, and the memory sees the request at N+1.
  - There is always one IDLE bubble after completion, so the same-cycle still-asserted request is never re-granted.
- Muxing is purely combinational from registered o_gnt:
  - The granted master's addr, data, wr_valid, wr_width and rd_ready drive memory.
  - i_wr_ready and i_rd_valid route only to the granted master. Non-granted masters see ready and valid at 0.
  - o_m_data is always driven from i_data.
- In IDLE: all memory-side outputs are 0, all o_m_* handshake outputs are 0, o_gnt is 0 and o_busy is 0.
- Read and write asserted together by the granted master: both are forwarded unchanged, and either handshake completes the grant. This is illegal usage and is not checked.
- Reset (async, mid-transaction allowed): immediately go to IDLE, o_gnt=0, last_gnt=1. All outputs are 0 while i_rst_n=0.
- A request changing address while granted is forwarded as-is. The arbiter does not latch master signals.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on every grant and increments each GRANTn cycle.
  - When the counter reaches TIMEOUT_CYCLES without completion: force IDLE, and pulse an extra output o_timeout high for 1 cycle together with o_timeout_m (1 bit, the index of the granted master).
  - The stuck master receives no handshake.
- When undefined: there is no counter and no o_timeout/o_timeout_m ports, and grants are held indefinitely.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_t enum (ARB_IDLE, ARB_GRANT0, ARB_GRANT1).
  - M_FETCH=0, M_EXEC=1 constants.
  - WIDTH_W=3 write-width constant, alongside `DATA_WIDTH from common.svh.
- One sub-module, rr_pick2: combinational two-way round-robin picker taking req[1:0] and last_gnt and producing a one-hot pick.
- State, counter and mux logic stay in mem_arbiter.

Test Plan:
- Single read: m0 rd_ready=1, addr=0x100 at cycle 0. Expect o_gnt=01 and o_addr=0x100 at cycle 1. Memory rd_valid at cycle 3 with data 0xDEADBEEF gives o_m_rd_valid=01, then IDLE at cycle 4.
- Tie: m0 and m1 both request from reset. Expect m0 granted first, m1 granted after m0 completes plus 1 bubble, and m0 next when both request again.
- Write routing: m1 wr_valid, addr=0x2000, data=0x55, width=3'b010 while m0 is idle. Expect memory to see exactly these values and o_m_wr_ready=10 only in the i_wr_ready cycle.
- Withdrawal: m1 granted, then drops its request before memory responds. Expect IDLE next cycle, and a pending m0 granted one cycle later.
- Reset: assert i_rst_n=0 mid-grant, asynchronously between clock edges. Expect o_gnt=0 and all outputs 0 immediately, and after release m0 wins a tie.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): m0 is granted and memory never responds. Expect o_timeout pulse with o_timeout_m=0 after 8 grant cycles, then IDLE.
